// File: rtl/add_serial_arb.sv
// Round-robin arbiter/sequencer sharing one bit-serial adder among N requesters.
// Latency: grant in cycle t, add_en at t+1, response valid at t+2+LAT.
// Backpressure: response held in RESP until i_rsp_ready; no grants while busy.
module add_serial_arb #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2,
    parameter int LAT = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req_valid,
    input  logic [N*W-1:0]   i_req_a,
    input  logic [N*W-1:0]   i_req_b,
    output logic [N-1:0]     o_req_ready,
    output logic             o_rsp_valid,
    output logic [IDW-1:0]   o_rsp_id,
    output logic [W-1:0]     o_rsp_sum,
    input  logic             i_rsp_ready,
    output logic             o_add_en,
    output logic [W-1:0]     o_add_a,
    output logic [W-1:0]     o_add_b,
    input  logic [W-1:0]     i_add_out
);

    // Counter only ever holds LAT-1 down to 0.
    localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_ptr;
    logic [CW-1:0]  r_cnt;
    logic           r_add_en;
    logic [W-1:0]   r_add_a;
    logic [W-1:0]   r_add_b;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [W-1:0]   r_rsp_sum;

    logic           w_gnt_vld;
    logic [IDW-1:0] w_gnt_idx;
    logic [IDW-1:0] w_scan;

    // Round-robin pick: first pending requester after the last one granted.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 1; k <= N; k++) begin
            w_scan = IDW'((int'(r_ptr) + k) % N);
            if (!w_gnt_vld && i_req_valid[w_scan]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
    end

    // Grant is only visible while arbitrating; at most one bit set.
    always_comb begin
        o_req_ready = '0;
        if (r_state == S_ARB && w_gnt_vld) begin
            o_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Next-state logic for the ARB -> ISSUE -> WAIT -> RESP sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ARB:   if (w_gnt_vld) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
            S_RESP:  if (i_rsp_ready) w_next = S_ARB;
            default: w_next = S_ARB;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ARB;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath: capture operands on grant, count adder latency, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= IDW'(N - 1);
            r_cnt       <= '0;
            r_add_en    <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
        end else begin
            // add_en is high exactly for the ISSUE cycle.
            r_add_en <= (r_state == S_ARB) && w_gnt_vld;
            case (r_state)
                S_ARB: begin
                    if (w_gnt_vld) begin
                        r_add_a  <= i_req_a[w_gnt_idx*W +: W];
                        r_add_b  <= i_req_b[w_gnt_idx*W +: W];
                        r_rsp_id <= w_gnt_idx;
                        r_ptr    <= w_gnt_idx;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= CW'(LAT - 1);
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_sum   <= i_add_out;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_add_en    = r_add_en;
    assign o_add_a     = r_add_a;
    assign o_add_b     = r_add_b;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_sum   = r_rsp_sum;

endmodule

// File: tb/tb_add_serial_arb.sv
// Bench for add_serial_arb: behavioural adder, round-robin reference model,
// scoreboard queue of expected responses consumed by an independent monitor.
module tb_add_serial_arb;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;
    localparam int LAT = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_sum;
    logic             rsp_ready;
    logic             add_en;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic [W-1:0]     add_out;

    add_serial_arb #(.N(N), .W(W), .IDW(IDW), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .i_rsp_ready (rsp_ready),
        .o_add_en    (add_en),
        .o_add_a     (add_a),
        .o_add_b     (add_b),
        .i_add_out   (add_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural adder: result becomes stable LAT cycles after en; before that
    // its output is deliberately wrong so an early capture is visible.
    logic [W-1:0] m_sum;
    int           m_left;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sum  <= '0;
            m_left <= 0;
        end else if (add_en) begin
            m_sum  <= add_a + add_b;
            m_left <= LAT;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end
    end
    assign add_out = (m_left <= 1) ? m_sum : ~m_sum;

    typedef struct {
        int           id;
        logic [W-1:0] sum;
        int           due;
    } exp_t;

    exp_t         sbq[$];
    int           glog[$];
    int           gcyc[$];
    int           pcyc[$];
    logic [N-1:0] hs;
    int           n_rsp = 0;
    int           last_id = -1;
    logic [W-1:0] last_sum = '0;

    // Reference model: decides who must be granted and what they must receive.
    int           cyc = 0;
    int           m_last = N - 1;
    bit           m_busy = 0;
    int           m_en_cyc = -100;
    int           win;
    int           idx;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    initial begin : model_proc
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (rst) begin
                m_busy   = 0;
                m_last   = N - 1;
                m_en_cyc = -100;
                sbq.delete();
                hs = '0;
                continue;
            end
            win = -1;
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
            end
            exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("add_en", 32'(add_en), 32'(cyc == m_en_cyc));
            hs = req_ready & req_valid;
            if (win >= 0) begin
                e.id  = win;
                e.sum = req_a[win*W +: W] + req_b[win*W +: W];
                e.due = cyc + 2 + LAT;
                sbq.push_back(e);
                glog.push_back(win);
                gcyc.push_back(cyc);
                m_busy   = 1;
                m_last   = win;
                m_en_cyc = cyc + 1;
            end
            if (rsp_valid && rsp_ready) m_busy = 0;
        end
    end

    // Monitor: compares every presented response against the scoreboard head.
    int mcyc = 0;
    bit seen = 0;
    initial begin : mon_proc
        forever begin
            @(negedge clk);
            #4;
            mcyc++;
            if (rst) begin
                seen = 0;
                continue;
            end
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id=%0d sum=0x%0h, expected no response", rsp_id, rsp_sum);
                end else begin
                    if (!seen) chk("rsp_latency", mcyc, sbq[0].due);
                    seen = 1;
                    chk("rsp_id", 32'(rsp_id), sbq[0].id);
                    chk("rsp_sum", 32'(rsp_sum), 32'(sbq[0].sum));
                    if (rsp_ready) begin
                        last_id  = int'(rsp_id);
                        last_sum = rsp_sum;
                        pcyc.push_back(mcyc);
                        void'(sbq.pop_front());
                        seen = 0;
                        n_rsp++;
                    end
                end
            end else if (sbq.size() > 0 && !seen && mcyc > sbq[0].due) begin
                checks++;
                errors++;
                $display("FAIL rsp_missing: got no response by cycle %0d, expected one at %0d", mcyc, sbq[0].due);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    // Advance n cycles; granted requesters either drop or reload new operands.
    task automatic drive_cycles(input int n, input bit reload);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (hs[i] && req_valid[i]) begin
                    if (reload) set_req(i, W'($urandom), W'($urandom));
                    else req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_id"},    32'(rsp_id),    0);
        chk({tag, "_rsp_sum"},   32'(rsp_sum),   0);
        chk({tag, "_add_en"},    32'(add_en),    0);
        chk({tag, "_add_a"},     32'(add_a),     0);
        chk({tag, "_add_b"},     32'(add_b),     0);
    endtask

    int g0;
    int target;
    int budget;
    initial begin : main_proc
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("por");
        rst = 1'b0;

        // Single request.
        @(negedge clk);
        set_req(0, 8'h25, 8'h13);
        drive_cycles(16, 0);
        chk("single_sum", 32'(last_sum), 32'h38);
        chk("single_id", last_id, 0);

        // Wrap-around arithmetic.
        set_req(2, 8'hFF, 8'h01);
        drive_cycles(16, 0);
        chk("wrap_sum", 32'(last_sum), 32'h00);
        chk("wrap_id", last_id, 2);
        set_req(1, 8'h80, 8'h80);
        drive_cycles(16, 0);
        chk("wrap80_sum", 32'(last_sum), 32'h00);
        chk("wrap80_id", last_id, 1);

        // Backpressure: response stalls 20 cycles, pending requester 1 waits.
        rsp_ready = 1'b0;
        set_req(0, 8'h11, 8'h22);
        drive_cycles(12, 0);
        set_req(1, 8'h33, 8'h44);
        drive_cycles(20, 0);
        rsp_ready = 1'b1;
        drive_cycles(16, 0);
        chk("bp_grant_id", glog[$], 1);
        chk("bp_regrant_cycle", gcyc[$], pcyc[pcyc.size()-2] + 1);

        // Reset during WAIT cycle 4, then 0/3 contention.
        set_req(2, 8'h0F, 8'h01);
        drive_cycles(1, 0);
        drive_cycles(4, 0);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        g0 = glog.size();
        set_req(0, 8'h5A, 8'h21);
        set_req(3, 8'h7E, 8'h02);
        drive_cycles(30, 0);
        chk("rst_grants", glog.size() - g0, 2);
        chk("rst_first_0", glog[g0], 0);
        chk("rst_then_3", glog[g0+1], 3);
        chk("rst_sum3", 32'(last_sum), 32'h80);

        // Fairness: all four held valid for eight operations.
        g0 = glog.size();
        for (int i = 0; i < N; i++) set_req(i, W'($urandom), W'($urandom));
        drive_cycles(90, 1);
        req_valid = '0;
        drive_cycles(20, 0);
        chk("fair_count", glog.size() - g0, 8);
        for (int k = 0; k < 8; k++) begin
            if (g0 + k < glog.size()) chk("fair_order", glog[g0+k], k % N);
            if (k > 0 && g0 + k < gcyc.size()) chk("fair_spacing", gcyc[g0+k] - gcyc[g0+k-1], 12);
        end

        // Withdrawn request from requester 3 during WAIT.
        g0 = glog.size();
        set_req(0, 8'h40, 8'h02);
        drive_cycles(4, 0);
        set_req(3, 8'h99, 8'h01);
        @(negedge clk);
        req_valid[3] = 1'b0;
        drive_cycles(16, 0);
        chk("withdraw_grants", glog.size() - g0, 1);
        chk("withdraw_last", glog[$], 0);

        // Random run of 500 operations.
        target = n_rsp + 500;
        budget = 0;
        while (n_rsp < target && budget < 30000) begin
            @(negedge clk);
            budget++;
            rsp_ready = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if (hs[i]) req_valid[i] = 1'b0;
                    else if ($urandom % 64 == 0) req_valid[i] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    set_req(i, W'($urandom), W'($urandom));
                end
            end
        end
        chk("random_ops_done", 32'(n_rsp >= target), 1);
        req_valid = '0;
        rsp_ready = 1'b1;
        drive_cycles(30, 0);
        chk("drain_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/add_serial_arb.md
# add_serial_arb

Round-robin arbiter and sequencer that shares one 8-bit bit-serial adder (`add_serial`) among N requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the adder's `en`/`a`/`b`. It counts the adder's fixed latency, captures its result, and returns it with the requester id over a single valid/ready response port. It sits between the requester clients and the single adder instance.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `W`, default 8: operand/result width; must match the adder.
- `IDW`, default 2: id width; 2^IDW >= N.
- `LAT`, default 9: WAIT cycles from the adder accepting `en` to the cycle its result is stable (8 ADD cycles + 1 DONE cycle).
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input N: request pending, one bit per requester.
- `req_a` input N*W: operand A; requester i uses bits [i*W +: W].
- `req_b` input N*W: operand B; same packing as `req_a`.
- `req_ready` output N: grant/accept, one-hot or zero.
- `rsp_valid` output 1: result available.
- `rsp_id` output IDW: index of the requester that owns the result.
- `rsp_sum` output W: (a+b) mod 2^W.
- `rsp_ready` input 1: consumer accepts the response.
- `add_en` output 1: adder start; driven to adder `en`.
- `add_a` output W: adder operand A; registered.
- `add_b` output W: adder operand B; registered.
- `add_out` input W: adder `out`.

## Operation
- FSM states, in order: ARB, ISSUE, WAIT, RESP.
- ARB:
  - If any `req_valid` is set, grant index g is the first set bit scanning upward from `ptr+1`, wrapping modulo N.
  - `req_ready[g]=1` combinationally this cycle; the handshake completes this cycle.
  - At the edge: `add_a`/`add_b` ← requester g's operands, `rsp_id` ← g, `ptr` ← g, go to ISSUE.
  - If no `req_valid` is set, stay in ARB.
- ISSUE: `add_en=1` for exactly this one cycle. Load `cnt` ← LAT-1, go to WAIT.
- WAIT:
  - `add_en=0`.
  - `cnt` decrements each cycle.
  - In the cycle with `cnt==0`, at its ending edge: `rsp_sum` ← `add_out`, `rsp_valid` ← 1, go to RESP.
- RESP:
  - Hold `rsp_valid`, `rsp_id` and `rsp_sum` stable until `rsp_ready`.
  - On an edge with `rsp_valid && rsp_ready`: clear `rsp_valid` and go to ARB.
  - `add_en=0` throughout, which returns the adder to IDLE.
- `req_ready` is 0 in every state except ARB, and at most one bit is ever set.
- Requester obligation: `req_a`/`req_b` stay stable while `req_valid` is high and `req_ready` is low. Dropping `req_valid` before grant is legal; that requester is simply not granted.
- Fairness: the requester granted last has lowest priority on the next arbitration. With all N requesting, grants rotate 0,1,…,N-1,0.
- Arithmetic is the adder's: the carry out of bit W-1 is discarded. The block performs no arithmetic of its own.
- Reset values:
  - state=ARB, `ptr`=N-1 (requester 0 wins first), `cnt`=0.
  - `req_ready`=0, `add_en`=0, `add_a`=0, `add_b`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0.
- Reset mid-operation abandons the in-flight operation with no response. The adder is reset by the same `rst`.

## Timing
- Request granted in cycle t (ARB):
  - ISSUE at t+1.
  - WAIT at t+2 … t+1+LAT.
  - `rsp_valid` first high at t+2+LAT, which is t+11 at the defaults.
- Minimum period is LAT+3 = 12 cycles per operation with `rsp_ready` tied high. The next grant occurs in the cycle after the response handshake.
- Response backpressure stalls the FSM in RESP indefinitely. No request is accepted during the stall.
- Request arriving during ISSUE/WAIT/RESP waits until the next ARB cycle.
- `req_ready` is combinational from `req_valid`, `ptr` and state. Every other output is registered.

## Test plan
- Single request: `req_valid[0]` at t, a=0x25, b=0x13, `rsp_ready`=1 → `req_ready[0]` at t; `add_en` only at t+1; `rsp_valid` at t+11 with id=0, sum=0x38, held for 1 cycle.
- Wrap-around: a=0xFF, b=0x01 on requester 2 → sum=0x00, id=2. Also a=0x80, b=0x80 → sum=0x00.
- Fairness: all 4 requesters held valid with distinct operands for 8 operations → grant order 0,1,2,3,0,1,2,3; each sum and id correct; grants 12 cycles apart.
- Backpressure: `rsp_ready`=0 for 20 cycles after `rsp_valid` → response fields stable, `req_ready`=0 throughout. Raise `rsp_ready` → pending `req_valid[1]` granted in the cycle after the handshake.
- Reset mid-WAIT: assert `rst` at WAIT cycle 4 → all outputs at reset values immediately. After release, a new request completes with the correct sum, and requester 0 wins a simultaneous 0/3 contention.
- Withdrawn request: `req_valid[3]` pulses for 1 cycle during WAIT then drops → no grant to 3. Random 500-operation run with a behavioural adder model → every response matches the scoreboard.
